// File: rtl/seg7_arb_pkg.sv
// rtl/seg7_arb_pkg.sv - shared state type, widths and helpers for the 7-segment display arbiter
package seg7_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int DIG_W   = 32;
  localparam int TAG_LSB = 28;
  localparam int TAG_W   = DIG_W - TAG_LSB;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_display_arbiter_if.sv
// rtl/seg7_display_arbiter_if.sv - requester-side and display-side signals of the display arbiter
interface seg7_display_arbiter_if #(
  parameter int NREQ = 4
);
  import seg7_arb_pkg::*;

  localparam int OW = owner_w(NREQ);

  logic [NREQ-1:0]       iREQ;
  logic [DIG_W*NREQ-1:0] iDATA;
  logic [DIG_W-1:0]      oDIG;
  logic [NREQ-1:0]       oGNT;
  logic [OW-1:0]         oOWNER;
  logic                  oBUSY;

  modport master (
    output iREQ, iDATA,
    input  oDIG, oGNT, oOWNER, oBUSY
  );

  modport slave (
    input  iREQ, iDATA,
    output oDIG, oGNT, oOWNER, oBUSY
  );

endinterface

// File: rtl/seg7_rr_pick.sv
// rtl/seg7_rr_pick.sv - combinational rotating-priority picker starting just after the pointer
module seg7_rr_pick
  import seg7_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OW   = owner_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [OW-1:0]   ptr,
  output logic            valid,
  output logic [NREQ-1:0] onehot,
  output logic [OW-1:0]   idx
);

  logic [OW-1:0] cand;

  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    cand   = '0;
    // Scan farthest first so the nearest request after ptr is the last to overwrite.
    for (int i = NREQ; i >= 1; i--) begin
      cand = OW'((int'(ptr) + i) % NREQ);
      if (req[cand]) begin
        valid        = 1'b1;
        onehot       = '0;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/seg7_display_arbiter.sv
// rtl/seg7_display_arbiter.sv - round-robin time-sliced owner of the 8-digit display word
// Optional: SEG7_ARB_OWNER_TAG_EN puts the owner index in the leftmost digit.
module seg7_display_arbiter
  import seg7_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int SLICE_CYC = 50000000
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  seg7_display_arbiter_if.slave bus
);

  localparam int            OW       = owner_w(NREQ);
  localparam int            CW       = $clog2(SLICE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLICE_CYC - 1);
  localparam logic [OW-1:0] PTR_RST  = OW'(NREQ - 1);

  state_e           state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;

  logic             pick_valid;
  logic [NREQ-1:0]  pick_onehot;
  logic [OW-1:0]    pick_idx;

  logic [DIG_W-1:0] words [NREQ];
  logic [OW-1:0]    sel_idx;
  logic [DIG_W-1:0] sel_word;
  logic [DIG_W-1:0] sel_dig;
  logic             expiry;
  logic             others_req;

  seg7_rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .req    (bus.iREQ),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  for (genvar k = 0; k < NREQ; k++) begin : g_word
    assign words[k] = bus.iDATA[k*DIG_W +: DIG_W];
  end

  // In ARB the incoming winner's word is loaded; in HOLD the current owner is tracked live.
  assign sel_idx  = (state_q == ARB) ? pick_idx : owner_q;
  assign sel_word = words[sel_idx];

`ifdef SEG7_ARB_OWNER_TAG_EN
  assign sel_dig = {TAG_W'(sel_idx), sel_word[TAG_LSB-1:0]};
`else
  assign sel_dig = sel_word;
`endif

  assign expiry     = (cnt_q == CNT_LAST);
  assign others_req = |(bus.iREQ & ~gnt_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.iREQ) state_d = ARB;
      end
      ARB: begin
        gnt_d = '0;
        cnt_d = '0;
        if (pick_valid) begin
          state_d = HOLD;
          gnt_d   = pick_onehot;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          dig_d   = sel_dig;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        dig_d = sel_dig;
        cnt_d = cnt_q + 1'b1;
        // Release beats expiry; a lone owner re-arms its slice without dropping the grant.
        if (!bus.iREQ[owner_q]) begin
          state_d = ARB;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (expiry) begin
          cnt_d = '0;
          if (others_req) begin
            state_d = ARB;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      owner_q <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.oDIG   = dig_q;
  assign bus.oGNT   = gnt_q;
  assign bus.oOWNER = owner_q;
  assign bus.oBUSY  = (state_q == HOLD);

endmodule
